// File: rtl/usb_rw_controller_if.sv
// Host task bus and protocol-handler bus for usb_rw_controller.
// master = host/protocol side, slave = the controller.
interface usb_rw_controller_if;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 64;

    logic              start_read;
    logic              start_write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic              done;
    logic              success;
    logic              proto_req;
    logic              proto_is_in;
    logic [6:0]        proto_dev;
    logic [3:0]        proto_endp;
    logic [3:0]        proto_len;
    logic [DATA_W-1:0] proto_wdata;
    logic              proto_done;
    logic              proto_ok;
    logic [DATA_W-1:0] proto_rdata;

    modport master (
        output start_read, start_write, addr, wdata, proto_done, proto_ok, proto_rdata,
        input  rdata, busy, done, success, proto_req, proto_is_in, proto_dev,
               proto_endp, proto_len, proto_wdata
    );

    modport slave (
        input  start_read, start_write, addr, wdata, proto_done, proto_ok, proto_rdata,
        output rdata, busy, done, success, proto_req, proto_is_in, proto_dev,
               proto_endp, proto_len, proto_wdata
    );
endinterface

// File: rtl/usb_rw_controller.sv
// Sequences host memory read/write requests into address + data USB transactions with retry.
// Optional RW_WATCHDOG_EN adds a per-request cycle watchdog that aborts a stalled transaction.
module usb_rw_controller #(
    parameter logic [6:0]  DEV_ADDR  = 7'd5,
    parameter logic [3:0]  ADDR_ENDP = 4'd4,
    parameter logic [3:0]  DATA_ENDP = 4'd8,
    parameter int unsigned MAX_TRY   = 8
`ifdef RW_WATCHDOG_EN
    ,parameter int unsigned WDOG_CYC = 1024
`endif
) (
    input  logic                clk,
    input  logic                rst_L,
    usb_rw_controller_if.slave  bus
);
    localparam int unsigned TRY_W = $clog2(MAX_TRY + 1);

    typedef enum logic [2:0] {IDLE, ADDR, DATA, GAP, FIN} state_t;

    state_t           state;
    logic             is_write;
    logic             gap_data;
    logic [15:0]      addr_q;
    logic [63:0]      wdata_q;
    logic [TRY_W-1:0] try_cnt;
    logic [63:0]      rdata_q;
    logic             busy_q, done_q, success_q;
    logic             req_q, is_in_q;
    logic [6:0]       dev_q;
    logic [3:0]       endp_q, len_q;
    logic [63:0]      pwdata_q;
    logic             timeout;

`ifdef RW_WATCHDOG_EN
    localparam int unsigned WDOG_W = $clog2(WDOG_CYC + 1);
    logic [WDOG_W-1:0] wdog_cnt;

    // counts cycles of the current outstanding request; drops to 0 whenever req is low
    always_ff @(posedge clk) begin
        if (!rst_L || !req_q || bus.proto_done) begin
            wdog_cnt <= '0;
        end else begin
            wdog_cnt <= wdog_cnt + WDOG_W'(1);
        end
    end

    assign timeout = req_q && (wdog_cnt == WDOG_W'(WDOG_CYC - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_L) begin
            state     <= IDLE;
            is_write  <= 1'b0;
            gap_data  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            try_cnt   <= '0;
            rdata_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            success_q <= 1'b0;
            req_q     <= 1'b0;
            is_in_q   <= 1'b0;
            dev_q     <= '0;
            endp_q    <= '0;
            len_q     <= '0;
            pwdata_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start_write || bus.start_read) begin
                        is_write  <= bus.start_write;
                        addr_q    <= bus.addr;
                        if (bus.start_write) wdata_q <= bus.wdata;
                        busy_q    <= 1'b1;
                        success_q <= 1'b0;
                        try_cnt   <= '0;
                        req_q     <= 1'b1;
                        is_in_q   <= 1'b0;
                        dev_q     <= DEV_ADDR;
                        endp_q    <= ADDR_ENDP;
                        len_q     <= 4'd2;
                        pwdata_q  <= {48'b0, bus.addr};
                        state     <= ADDR;
                    end
                end
                ADDR, DATA: begin
                    if (!req_q) begin
                        req_q <= 1'b1;
                    end else if (bus.proto_done) begin
                        req_q <= 1'b0;
                        if (bus.proto_ok) begin
                            if (state == ADDR) begin
                                // payload registers switch while req is low for the spacer cycle
                                try_cnt  <= '0;
                                is_in_q  <= !is_write;
                                endp_q   <= DATA_ENDP;
                                len_q    <= 4'd8;
                                pwdata_q <= is_write ? wdata_q : 64'd0;
                                state    <= DATA;
                            end else begin
                                if (!is_write) rdata_q <= bus.proto_rdata;
                                success_q <= 1'b1;
                                done_q    <= 1'b1;
                                state     <= FIN;
                            end
                        end else if (try_cnt < TRY_W'(MAX_TRY - 1)) begin
                            try_cnt  <= try_cnt + TRY_W'(1);
                            gap_data <= (state == DATA);
                            state    <= GAP;
                        end else begin
                            success_q <= 1'b0;
                            done_q    <= 1'b1;
                            state     <= FIN;
                        end
                    end else if (timeout) begin
                        req_q     <= 1'b0;
                        success_q <= 1'b0;
                        done_q    <= 1'b1;
                        state     <= FIN;
                    end
                end
                GAP: begin
                    req_q <= 1'b1;
                    state <= gap_data ? DATA : ADDR;
                end
                FIN: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rdata       = rdata_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.success     = success_q;
    assign bus.proto_req   = req_q;
    assign bus.proto_is_in = is_in_q;
    assign bus.proto_dev   = dev_q;
    assign bus.proto_endp  = endp_q;
    assign bus.proto_len   = len_q;
    assign bus.proto_wdata = pwdata_q;
endmodule

// File: tb/tb_usb_rw_controller.sv
// Self-checking bench for usb_rw_controller: scripted/random NAK responder plus a
// transaction-level model of expected request counts, outcome and read data.
module tb_usb_rw_controller;
    localparam logic [6:0] DEV_ADDR  = 7'd5;
    localparam logic [3:0] ADDR_ENDP = 4'd4;
    localparam logic [3:0] DATA_ENDP = 4'd8;
    localparam int         MAX_TRY   = 8;
    localparam int         WDOG_CYC  = 1024;

    typedef struct {
        bit          is_in;
        logic [3:0]  endp;
        logic [3:0]  len;
        logic [63:0] wd;
        logic [6:0]  dev;
    } req_t;

    logic clk = 1'b0;
    logic rst_L;
    usb_rw_controller_if bus();

    usb_rw_controller dut (
        .clk   (clk),
        .rst_L (rst_L),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // responder state
    req_t        req_log[$];
    int          addr_fail_left = 0;
    int          data_fail_left = 0;
    logic [63:0] resp_rdata = '0;
    bit          stall_all = 0;
    bit          stall_data = 0;
    bit          spur_en = 0;
    int          gap_viol = 0;
    int          last_done_cyc = 0;
    logic [63:0] rdata_model = '0;

    // protocol handler model: random response delay, NAKs consumed from per-phase budgets
    initial begin
        bit pending;
        bit prev_req;
        bit ok;
        int delay;
        pending = 0;
        prev_req = 0;
        delay = 0;
        bus.proto_done = 1'b0;
        bus.proto_ok = 1'b0;
        bus.proto_rdata = '0;
        forever begin
            @(negedge clk);
            bus.proto_done = 1'b0;
            bus.proto_ok = 1'b0;
            bus.proto_rdata = {$urandom, $urandom};
            if (rst_L !== 1'b1) begin
                pending = 0;
                prev_req = 0;
            end else begin
                if (bus.proto_req === 1'b1) begin
                    if (!pending) begin
                        if (prev_req) gap_viol++;
                        pending = 1;
                        delay = $urandom_range(0, 3);
                        req_log.push_back('{bus.proto_is_in, bus.proto_endp, bus.proto_len,
                                            bus.proto_wdata, bus.proto_dev});
                    end
                    if (stall_all || (stall_data && bus.proto_endp == DATA_ENDP)) begin
                        pending = 1;
                    end else if (delay > 0) begin
                        delay--;
                    end else begin
                        pending = 0;
                        last_done_cyc = cyc;
                        if (bus.proto_endp == ADDR_ENDP) begin
                            ok = (addr_fail_left == 0);
                            if (!ok) addr_fail_left--;
                        end else begin
                            ok = (data_fail_left == 0);
                            if (!ok) data_fail_left--;
                        end
                        bus.proto_done = 1'b1;
                        bus.proto_ok = ok;
                        bus.proto_rdata = ok ? resp_rdata : ~resp_rdata;
                    end
                end else begin
                    pending = 0;
                    if (spur_en && $urandom_range(0, 3) == 0) begin
                        bus.proto_done = 1'b1;
                        bus.proto_ok = 1'b1;
                    end
                end
                prev_req = (bus.proto_req === 1'b1);
            end
        end
    end

    task automatic check_all_zero(input string name);
        logic [147:0] snap;
        snap = {bus.busy, bus.done, bus.success, bus.proto_req, bus.proto_is_in, bus.proto_dev,
                bus.proto_endp, bus.proto_len, bus.proto_wdata, bus.rdata};
        checks++;
        if (snap !== '0) begin
            failures++;
            $display("FAIL %s: outputs=%h required all zero", name, snap);
        end
    endtask

    // one complete host operation compared against the transaction-level expectation
    task automatic run_op(input bit wr, input bit both, input bit poke, input logic [15:0] a,
                          input logic [63:0] d, input int fa, input int fd, input logic [63:0] rd_ret);
        int exp_na, exp_nd, na, nd, waited;
        bit addr_ok, exp_succ, order_ok, fmt_ok;
        logic [63:0] exp_rdata;
        addr_ok   = fa < MAX_TRY;
        exp_na    = addr_ok ? fa + 1 : MAX_TRY;
        exp_nd    = !addr_ok ? 0 : ((fd < MAX_TRY) ? fd + 1 : MAX_TRY);
        exp_succ  = addr_ok && (fd < MAX_TRY);
        exp_rdata = (exp_succ && !wr) ? rd_ret : rdata_model;
        addr_fail_left = fa;
        data_fail_left = fd;
        resp_rdata = rd_ret;
        req_log.delete();
        gap_viol = 0;

        @(negedge clk);
        bus.start_write = wr;
        bus.start_read  = !wr || both;
        bus.addr  = a;
        bus.wdata = d;
        @(negedge clk);
        bus.start_write = 1'b0;
        bus.start_read  = 1'b0;
        bus.addr  = 16'($urandom);
        bus.wdata = {$urandom, $urandom};
        checks++;
        if (bus.busy !== 1'b1 || bus.proto_req !== 1'b1) begin
            failures++;
            $display("FAIL start_latency: busy=%b req=%b required 1/1", bus.busy, bus.proto_req);
        end
        if (poke) begin
            @(negedge clk);
            bus.start_write = 1'b1;
            bus.start_read  = 1'b1;
            bus.addr  = ~a;
            bus.wdata = ~d;
            @(negedge clk);
            bus.start_write = 1'b0;
            bus.start_read  = 1'b0;
        end

        waited = 0;
        while (bus.done !== 1'b1 && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (waited >= 1000) begin
            failures++;
            $display("FAIL done_timeout: waited=%0d cycles required done before 1000", waited);
            return;
        end
        checks++;
        if (bus.success !== exp_succ || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL done_status: success=%b busy=%b required %b/1", bus.success, bus.busy, exp_succ);
        end
        checks++;
        if (cyc != last_done_cyc + 1) begin
            failures++;
            $display("FAIL done_latency: cycle=%0d required %0d", cyc, last_done_cyc + 1);
        end
        checks++;
        if (bus.rdata !== exp_rdata) begin
            failures++;
            $display("FAIL rdata: got %h required %h", bus.rdata, exp_rdata);
        end

        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.success !== exp_succ) begin
            failures++;
            $display("FAIL after_done: done=%b busy=%b success=%b required 0/0/%b",
                     bus.done, bus.busy, bus.success, exp_succ);
        end

        na = 0;
        nd = 0;
        order_ok = 1;
        fmt_ok = 1;
        foreach (req_log[i]) begin
            if (req_log[i].endp == ADDR_ENDP) begin
                na++;
                if (nd != 0) order_ok = 0;
                if (req_log[i].is_in || req_log[i].len != 4'd2 || req_log[i].wd != {48'h0, a} ||
                    req_log[i].dev != DEV_ADDR) fmt_ok = 0;
            end else if (req_log[i].endp == DATA_ENDP) begin
                nd++;
                if (req_log[i].is_in != !wr || req_log[i].dev != DEV_ADDR) fmt_ok = 0;
                if (wr && (req_log[i].len != 4'd8 || req_log[i].wd != d)) fmt_ok = 0;
            end else begin
                fmt_ok = 0;
            end
        end
        checks++;
        if (na != exp_na || nd != exp_nd) begin
            failures++;
            $display("FAIL req_counts: addr=%0d data=%0d required %0d/%0d", na, nd, exp_na, exp_nd);
        end
        checks++;
        if (!order_ok || !fmt_ok || gap_viol != 0) begin
            failures++;
            $display("FAIL req_format: order=%b fields=%b gap_viol=%0d required 1/1/0", order_ok, fmt_ok, gap_viol);
        end
        rdata_model = exp_rdata;
    endtask

    task automatic test_reset();
        check_all_zero("reset_state");
    endtask

    task automatic test_write_all_ones();
        run_op(1'b1, 1'b0, 1'b0, 16'hFFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 64'h0);
    endtask

    task automatic test_read_all_ones();
        run_op(1'b0, 1'b0, 1'b0, 16'hFFFF, 64'h0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF);
    endtask

    task automatic test_addr_retry();
        run_op(1'b1, 1'b0, 1'b0, 16'h0001, 64'h0100, 3, 0, 64'h0);
    endtask

    task automatic test_data_fail();
        run_op(1'b0, 1'b0, 1'b0, 16'h1234, 64'h0, 0, MAX_TRY, 64'hDEAD_BEEF_0BAD_F00D);
    endtask

    task automatic test_addr_abort();
        run_op(1'b1, 1'b0, 1'b0, 16'hA5A5, 64'h0123_4567_89AB_CDEF, MAX_TRY, 0, 64'h0);
    endtask

    task automatic test_busy_ignore();
        run_op(1'b0, 1'b0, 1'b1, 16'h7E57, 64'h0, 1, 1, 64'h1122_3344_5566_7788);
        run_op(1'b1, 1'b0, 1'b1, 16'h0F0F, 64'hCAFE_F00D_1234_5678, 0, 2, 64'h0);
    endtask

    task automatic test_both_starts();
        run_op(1'b1, 1'b1, 1'b0, 16'hBEEF, 64'h5555_AAAA_5555_AAAA, 0, 0, 64'h9999_9999_9999_9999);
    endtask

    task automatic test_spurious_idle();
        int bad;
        bad = 0;
        spur_en = 1;
        repeat (20) begin
            @(negedge clk);
            if (bus.busy !== 1'b0 || bus.proto_req !== 1'b0 || bus.done !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL spurious_idle: bad_cycles=%0d required 0", bad);
        end
    endtask

    task automatic test_random();
        bit wr;
        int fa, fd;
        repeat (24) begin
            wr = 1'($urandom_range(0, 1));
            fa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : 0;
            fd = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : 0;
            run_op(wr, 1'b0, 1'b0, 16'($urandom), {$urandom, $urandom}, fa, fd, {$urandom, $urandom});
        end
    endtask

    task automatic test_reset_mid_data();
        int waited, bad;
        stall_data = 1;
        addr_fail_left = 0;
        data_fail_left = 0;
        @(negedge clk);
        bus.start_read = 1'b1;
        bus.addr = 16'h4242;
        @(negedge clk);
        bus.start_read = 1'b0;
        waited = 0;
        while (!(bus.proto_req === 1'b1 && bus.proto_endp === DATA_ENDP) && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (waited >= 200) begin
            failures++;
            $display("FAIL reach_data: waited=%0d cycles required data phase before 200", waited);
        end
        rst_L = 1'b0;
        @(negedge clk);
        check_all_zero("reset_mid_data");
        rst_L = 1'b1;
        stall_data = 0;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.proto_req !== 1'b0 || bus.busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL post_reset_quiet: bad_cycles=%0d required 0", bad);
        end
        rdata_model = '0;
    endtask

`ifdef RW_WATCHDOG_EN
    task automatic test_watchdog();
        int high;
        stall_all = 1;
        @(negedge clk);
        bus.start_write = 1'b1;
        bus.addr = 16'h0BAD;
        bus.wdata = 64'h1;
        @(negedge clk);
        bus.start_write = 1'b0;
        high = 0;
        while (bus.proto_req === 1'b1 && high < 3000) begin
            high++;
            @(negedge clk);
        end
        checks++;
        if (high != WDOG_CYC) begin
            failures++;
            $display("FAIL wdog_len: req_high=%0d required %0d", high, WDOG_CYC);
        end
        checks++;
        if (bus.done !== 1'b1 || bus.success !== 1'b0) begin
            failures++;
            $display("FAIL wdog_done: done=%b success=%b required 1/0", bus.done, bus.success);
        end
        stall_all = 0;
        repeat (3) @(negedge clk);
    endtask
`endif

    initial begin
        rst_L = 1'b0;
        bus.start_read = 1'b0;
        bus.start_write = 1'b0;
        bus.addr = '0;
        bus.wdata = '0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_L = 1'b1;
        test_write_all_ones();
        test_read_all_ones();
        test_addr_retry();
        test_data_fail();
        test_addr_abort();
        test_busy_ignore();
        test_both_starts();
        test_spurious_idle();
        test_random();
        spur_en = 0;
        test_reset_mid_data();
`ifdef RW_WATCHDOG_EN
        test_watchdog();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
